// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx
//   Turns two tone-sequencer note divisors into square-wave PCM samples and
//   streams them to the stereo DAC as 16-bit I2S.
//
// Ports
//   clk            system clock (100 MHz)
//   rst_n          asynchronous active-low reset
//   note_div_left  left full-period count in clk cycles; 0 or 1 = silent
//   note_div_right right full-period count in clk cycles; 0 or 1 = silent
//   volume         (only with AUDIO_VOLUME_CTRL_EN) 0 = mute, 7 = full AMP
//   audio_mclk     DAC master clock, clk/4
//   audio_lrck     word select, clk/512; 0 = left, 1 = right
//   audio_sck      bit clock, clk/16
//   audio_sdin     serial data, I2S (MSB first, one-bit delay after LRCK)
//
// Build option
//   `define AUDIO_VOLUME_CTRL_EN adds the volume port; amplitude becomes
//   AMP >> (7 - volume), with volume 0 forcing silence. Volume is only
//   sampled when a frame is latched.
module audio_i2s_tx #(
    parameter int unsigned         SAMPLE_W = 16,
    parameter logic [SAMPLE_W-1:0] AMP      = 16'h4000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [21:0] note_div_left,
    input  logic [21:0] note_div_right,
`ifdef AUDIO_VOLUME_CTRL_EN
    input  logic [2:0]  volume,
`endif
    output logic        audio_mclk,
    output logic        audio_lrck,
    output logic        audio_sck,
    output logic        audio_sdin
);

    // Next tone-counter value: wraps once it reaches div-1 or has overshot a
    // divisor that just shrank; held at 0 while silent.
    function automatic logic [21:0] tone_next(input logic [21:0] tcnt,
                                              input logic [21:0] div);
        if (div <= 22'd1) begin
            return '0;
        end else if (tcnt >= div - 22'd1) begin
            return '0;
        end else begin
            return tcnt + 22'd1;
        end
    endfunction

    // Square level: +amp in the first half-period, -amp in the second.
    function automatic logic [SAMPLE_W-1:0] tone_level(input logic [21:0]         tcnt,
                                                       input logic [21:0]         div,
                                                       input logic [SAMPLE_W-1:0] amp_val);
        if (div <= 22'd1) begin
            return '0;
        end else if (tcnt < (div >> 1)) begin
            return amp_val;
        end else begin
            return -amp_val;
        end
    endfunction

    logic [8:0]          div_cnt_q, div_cnt_d;
    logic [21:0]         tcnt_l_q, tcnt_l_d;
    logic [21:0]         tcnt_r_q, tcnt_r_d;
    logic [SAMPLE_W-1:0] l_lat_q, r_lat_q;
    logic [SAMPLE_W-1:0] l_sample, r_sample;
    logic [SAMPLE_W-1:0] amp;
    logic                sdin_q, sdin_d;
    logic [4:0]          next_slot;
    logic [3:0]          bit_idx;
    logic                frame_wrap;

`ifdef AUDIO_VOLUME_CTRL_EN
    always_comb begin
        if (volume == 3'd0) begin
            amp = '0;
        end else begin
            amp = AMP >> (3'd7 - volume);
        end
    end
`else
    assign amp = AMP;
`endif

    assign frame_wrap = (div_cnt_q == 9'd511);

    always_comb begin
        div_cnt_d = div_cnt_q + 9'd1;
        tcnt_l_d  = tone_next(tcnt_l_q, note_div_left);
        tcnt_r_d  = tone_next(tcnt_r_q, note_div_right);
        // Samples use the pre-edge counters, so a tone wrap coinciding with
        // the frame wrap latches the old phase.
        l_sample  = tone_level(tcnt_l_q, note_div_left, amp);
        r_sample  = tone_level(tcnt_r_q, note_div_right, amp);
    end

    // Serial data for the slot that starts on the coming SCK falling edge.
    // (-slot) mod 16 maps slots 1..16 to bits 15..0 and 17..31 to 15..1.
    always_comb begin
        sdin_d    = sdin_q;
        next_slot = div_cnt_q[8:4] + 5'd1;
        bit_idx   = 4'(5'd0 - next_slot);
        if (div_cnt_q[3:0] == 4'hF) begin
            if (next_slot == 5'd0) begin
                // Trailing LSB of the right word; the latch is still the
                // previous frame's value on this edge.
                sdin_d = r_lat_q[0];
            end else if (next_slot <= 5'd16) begin
                sdin_d = l_lat_q[bit_idx];
            end else begin
                sdin_d = r_lat_q[bit_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            tcnt_l_q  <= '0;
            tcnt_r_q  <= '0;
            l_lat_q   <= '0;
            r_lat_q   <= '0;
            sdin_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            tcnt_l_q  <= tcnt_l_d;
            tcnt_r_q  <= tcnt_r_d;
            sdin_q    <= sdin_d;
            if (frame_wrap) begin
                l_lat_q <= l_sample;
                r_lat_q <= r_sample;
            end
        end
    end

    // All clocks come straight from one counter register, so they stay
    // phase-aligned with each other and with sdin.
    assign audio_mclk = div_cnt_q[1];
    assign audio_sck  = div_cnt_q[3];
    assign audio_lrck = div_cnt_q[8];
    assign audio_sdin = sdin_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
`timescale 1ns/1ps
module tb_audio_i2s_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [21:0] note_div_left;
    logic [21:0] note_div_right;
    logic        audio_mclk;
    logic        audio_lrck;
    logic        audio_sck;
    logic        audio_sdin;
`ifdef AUDIO_VOLUME_CTRL_EN
    logic [2:0]  volume;
`endif

    audio_i2s_tx dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .note_div_left  (note_div_left),
        .note_div_right (note_div_right),
`ifdef AUDIO_VOLUME_CTRL_EN
        .volume         (volume),
`endif
        .audio_mclk     (audio_mclk),
        .audio_lrck     (audio_lrck),
        .audio_sck      (audio_sck),
        .audio_sdin     (audio_sdin)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [21:0] dl;
        logic [21:0] dr;
        logic [15:0] el;
        logic [15:0] er;
    } vec_t;

    vec_t        vecs [8];
    int          tests = 0;
    int          fails = 0;
    int          n = 0;          // clk edges since reset release == div_cnt mod 512
    int          pend_n = -1;    // edge count at which note_div_left switches
    logic [21:0] pend_div = '0;
    int          timing_errs = 0;
    int          stable_errs = 0;
    logic        prev_sdin = 1'b0;
`ifdef AUDIO_VOLUME_CTRL_EN
    int          vol_n = -1;
    logic [2:0]  vol_val = 3'd7;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clk edge; sample #1 later and track clock phase / sdin stability.
    task automatic step();
        @(posedge clk);
        #1;
        n++;
        if (audio_mclk !== n[1] || audio_sck !== n[3] || audio_lrck !== n[8]) timing_errs++;
        if (n[3:0] != 4'd0 && audio_sdin !== prev_sdin) stable_errs++;
        prev_sdin = audio_sdin;
        if (n == pend_n) note_div_left = pend_div;
`ifdef AUDIO_VOLUME_CTRL_EN
        if (n == vol_n) volume = vol_val;
`endif
    endtask

    task automatic wait_until(input int t);
        while (n < t) step();
    endtask

    task automatic check_timing(input string name);
        check({name, "_clocks"}, 32'(timing_errs), 32'd0);
        check({name, "_sdin_stable"}, 32'(stable_errs), 32'd0);
        timing_errs = 0;
        stable_errs = 0;
    endtask

    // Decode the words carried in frame f (latched at the end of frame f-1).
    task automatic capture_frame(input int f, output logic [15:0] l, output logic [15:0] r,
                                 output logic s0);
        int base;
        base = 512 * f;
        wait_until(base + 8);
        s0 = audio_sdin;
        for (int k = 1; k <= 16; k++) begin
            wait_until(base + 16 * k + 8);
            l[16 - k] = audio_sdin;
        end
        for (int k = 17; k <= 31; k++) begin
            wait_until(base + 16 * k + 8);
            r[32 - k] = audio_sdin;
        end
        wait_until(base + 512 + 8);
        r[0] = audio_sdin;
    endtask

    task automatic do_reset(input logic [21:0] dl, input logic [21:0] dr);
        rst_n = 1'b0;
        note_div_left = dl;
        note_div_right = dr;
        pend_n = -1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        prev_sdin = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] l, r;
        logic        s0;

        vecs[0] = '{dl: 22'd0,      dr: 22'd0,      el: 16'h0000, er: 16'h0000};
        vecs[1] = '{dl: 22'd227272, dr: 22'd0,      el: 16'h4000, er: 16'h0000};
        vecs[2] = '{dl: 22'd227272, dr: 22'd227272, el: 16'h4000, er: 16'h4000};
        vecs[3] = '{dl: 22'd1,      dr: 22'd1000,   el: 16'h0000, er: 16'hC000};
        vecs[4] = '{dl: 22'd1024,   dr: 22'd1022,   el: 16'h4000, er: 16'hC000};
        vecs[5] = '{dl: 22'd1023,   dr: 22'd500,    el: 16'hC000, er: 16'h4000};
        vecs[6] = '{dl: 22'd2,      dr: 22'd3,      el: 16'hC000, er: 16'hC000};
        vecs[7] = '{dl: 22'd512,    dr: 22'd4,      el: 16'hC000, er: 16'hC000};

        rst_n = 1'b0;
        note_div_left = '0;
        note_div_right = '0;
`ifdef AUDIO_VOLUME_CTRL_EN
        volume = 3'd7;
`endif
        #12;
        check("reset_outputs", 32'({audio_mclk, audio_sck, audio_lrck, audio_sdin}), 32'd0);

        // Silent divisors: everything zero, clocks checked every cycle.
        do_reset(22'd0, 22'd0);
        capture_frame(0, l, r, s0);
        check("silent_frame0", 32'({l, r, 15'd0, s0}), 32'd0);
        check_timing("silent");

        // Frame latched at div_cnt 511 sees tcnt = 511 mod div.
        foreach (vecs[i]) begin
            do_reset(vecs[i].dl, vecs[i].dr);
            capture_frame(1, l, r, s0);
            check($sformatf("vec%0d_left", i), 32'(l), 32'(vecs[i].el));
            check($sformatf("vec%0d_right", i), 32'(r), 32'(vecs[i].er));
            check($sformatf("vec%0d_slot0", i), 32'(s0), 32'd0);
        end
        check_timing("table");

        // Tone toggling across frames, then a divisor shrink mid-frame:
        // tcnt=1600 >= 999 wraps, new tone high at the next latch (tcnt 446).
        do_reset(22'd2048, 22'd0);
        pend_n = 1600;
        pend_div = 22'd1000;
        capture_frame(1, l, r, s0);
        check("toggle_f1_left", 32'(l), 32'h4000);
        capture_frame(2, l, r, s0);
        check("toggle_f2_left", 32'(l), 32'h4000);
        capture_frame(3, l, r, s0);
        check("toggle_f3_left", 32'(l), 32'hC000);
        check("toggle_f3_right", 32'(r), 32'h0000);
        capture_frame(4, l, r, s0);
        check("shrink_f4_left", 32'(l), 32'h4000);
        check_timing("toggle");

        // Asynchronous reset at div_cnt = 300, no clock edge needed.
        do_reset(22'd227272, 22'd227272);
        wait_until(512 + 300);
        check("pre_reset_sck_lrck", 32'({audio_sck, audio_lrck}), 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'({audio_mclk, audio_sck, audio_lrck, audio_sdin}),
              32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        prev_sdin = 1'b0;
        capture_frame(0, l, r, s0);
        check("post_reset_frame0", 32'({l, r}), 32'd0);
        check("post_reset_slot0", 32'(s0), 32'd0);
        capture_frame(1, l, r, s0);
        check("post_reset_f1", 32'({l, r}), 32'h40004000);
        check_timing("reset");

`ifdef AUDIO_VOLUME_CTRL_EN
        // Volume changes mid-frame only show in the next frame.
        do_reset(22'd227272, 22'd0);
        vol_n = 600;
        vol_val = 3'd5;
        capture_frame(1, l, r, s0);
        check("vol7_left", 32'(l), 32'h4000);
        vol_n = 1100;
        vol_val = 3'd0;
        capture_frame(2, l, r, s0);
        check("vol5_left", 32'(l), 32'h1000);
        capture_frame(3, l, r, s0);
        check("vol0_left", 32'(l), 32'h0000);
        check_timing("volume");
        volume = 3'd7;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
